// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory interface types, plus the responder FSM state encoding.
// ramstate_t and word_t are the types the caches and memory control already use.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_DONE,
        RS_ERR
    } ramresp_state_t;

    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

    localparam int RAM_CNT_W = 4;

    function automatic ramstate_t to_ramstate(input ramresp_state_t s);
        case (s)
            RS_WAIT: return BUSY;
            RS_DONE: return ACCESS;
            RS_ERR:  return ERROR;
            default: return FREE;
        endcase
    endfunction

endpackage

// File: rtl/ram_word_array.sv
// Word storage behind the latency responder: one synchronous write port,
// one combinational read port, whole array cleared by the async reset.
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  word_t              wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output word_t              rdata
);

    word_t mem_q [2**DEPTH_W];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 2**DEPTH_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_latency_responder.sv
// Memory-side responder: holds BUSY for LAT cycles per request, then ACCESS for one
// cycle, committing reads/writes to ram_word_array. Illegal requests report ERROR.
module ram_latency_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 8
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam logic [RAM_CNT_W-1:0] CNT_RELOAD = RAM_CNT_W'(LAT - 1);

    ramresp_state_t         state_q, state_d;
    logic [RAM_CNT_W-1:0]   cnt_q, cnt_d;
    ram_req_t               req_q, req_d;
    word_t                  ramload_q, ramload_d;

    ram_req_t               live_req;
    logic                   req_present;
    logic                   req_illegal;
    logic                   mem_we;
    logic [DEPTH_W-1:0]     index;
    word_t                  rdata;

    assign live_req    = '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore};
    assign req_present = ramREN | ramWEN;
    // Out-of-range addresses must error rather than alias onto low words.
    assign req_illegal = (ramREN & ramWEN)
                       | (ramaddr[1:0] != 2'b00)
                       | ((ramaddr >> (DEPTH_W + 2)) != '0);
    assign index       = req_q.addr[DEPTH_W+1:2];

    ram_word_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (mem_we),
        .waddr (index),
        .wdata (req_q.store),
        .raddr (index),
        .rdata (rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        ramload_d = ramload_q;
        mem_we    = 1'b0;

        unique case (state_q)
            RS_WAIT: begin
                if (!req_present) begin
                    state_d = RS_IDLE;
                end else if (live_req != req_q) begin
                    if (req_illegal) begin
                        state_d   = RS_ERR;
                        ramload_d = '0;
                    end else begin
                        req_d = live_req;
                        cnt_d = CNT_RELOAD;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RS_DONE;
                    if (req_q.wen) begin
                        mem_we    = 1'b1;
                        ramload_d = req_q.store;
                    end else begin
                        ramload_d = rdata;
                    end
                end
            end
            default: begin
                if (!req_present) begin
                    state_d = RS_IDLE;
                end else if (req_illegal) begin
                    state_d   = RS_ERR;
                    ramload_d = '0;
                end else begin
                    state_d = RS_WAIT;
                    req_d   = live_req;
                    cnt_d   = CNT_RELOAD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RS_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            ramload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            ramload_q <= ramload_d;
        end
    end

    assign ramstate = to_ramstate(state_q);
    assign ramload  = ramload_q;

endmodule

// File: tb/tb_ram_latency_responder.sv
// Self-checking bench for ram_latency_responder: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_ram_latency_responder;
    import cpu_types_pkg::*;

    localparam int LAT     = 2;
    localparam int DEPTH_W = 8;
    localparam int WORDS   = 1 << DEPTH_W;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } tb_req_t;

    ramstate_t exp_state;
    tb_req_t   cap;
    int        waited;
    word_t     exp_load;
    word_t     model_mem [WORDS];

    ram_latency_responder #(
        .LAT     (LAT),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input word_t got, input word_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic bit isLegal(input tb_req_t r);
        return !(r.ren && r.wen) && (r.addr % 4 == 0) && (r.addr < 32'(WORDS * 4));
    endfunction

    task automatic modelReset();
        exp_state = FREE;
        exp_load  = '0;
        waited    = 0;
        cap       = '0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    endtask

    // One clock edge of the reference: a transaction needs LAT unchanged BUSY cycles.
    task automatic modelStep(input tb_req_t live);
        bit present;
        present = live.ren || live.wen;
        if (!present) begin
            exp_state = FREE;
        end else if (exp_state != BUSY || live != cap) begin
            if (!isLegal(live)) begin
                exp_state = ERROR;
                exp_load  = '0;
            end else begin
                cap       = live;
                waited    = 1;
                exp_state = BUSY;
            end
        end else if (waited < LAT) begin
            waited++;
        end else begin
            if (cap.wen) begin
                model_mem[cap.addr / 4] = cap.store;
                exp_load = cap.store;
            end else begin
                exp_load = model_mem[cap.addr / 4];
            end
            exp_state = ACCESS;
        end
    endtask

    task automatic applyStimulus(input logic ren, input logic wen, input word_t addr,
                                 input word_t store);
        tb_req_t live;
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = addr;
        ramstore = store;
        live     = '{ren: ren, wen: wen, addr: addr, store: store};
        @(posedge CLK);
        if (!nRST) modelReset();
        else modelStep(live);
        #1;
        checkOutput("state", 32'(ramstate), 32'(exp_state));
        if (exp_state == ACCESS) checkOutput("load", ramload, exp_load);
        if (exp_state == ERROR) checkOutput("err_load", ramload, 32'h0);
    endtask

    task automatic readWord(input word_t addr, input word_t want, input string tag);
        applyStimulus(1'b1, 1'b0, addr, '0);
        applyStimulus(1'b1, 1'b0, addr, '0);
        applyStimulus(1'b1, 1'b0, addr, '0);
        checkOutput({tag, "_st"}, 32'(ramstate), 32'(ACCESS));
        checkOutput(tag, ramload, want);
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        tb_req_t cur;
        int      kind;

        nRST     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_state", 32'(ramstate), 32'(FREE));
        checkOutput("rst_load", ramload, 32'h0);
        nRST = 1'b1;
        readWord(32'h40, 32'h0, "rst_rd40");

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        checkOutput("wr_busy1", 32'(ramstate), 32'(BUSY));
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        checkOutput("wr_busy2", 32'(ramstate), 32'(BUSY));
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        checkOutput("wr_access", 32'(ramstate), 32'(ACCESS));
        readWord(32'h10, 32'hDEADBEEF, "rd_after_wr");

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h4, '0);
            checkOutput("held_rd", 32'(ramstate), (i % 3 == 2) ? 32'(ACCESS) : 32'(BUSY));
        end
        applyStimulus(1'b0, 1'b0, '0, '0);

        applyStimulus(1'b1, 1'b0, 32'h8, '0);
        applyStimulus(1'b1, 1'b0, 32'h8, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'hC, '0);
            checkOutput("restart", 32'(ramstate), (i == 2) ? 32'(ACCESS) : 32'(BUSY));
        end
        applyStimulus(1'b0, 1'b0, '0, '0);

        applyStimulus(1'b1, 1'b1, 32'h10, 32'h55555555);
        checkOutput("err_both", 32'(ramstate), 32'(ERROR));
        applyStimulus(1'b1, 1'b0, 32'h2, '0);
        checkOutput("err_misalign", 32'(ramstate), 32'(ERROR));
        applyStimulus(1'b0, 1'b1, 32'h400, 32'h66666666);
        checkOutput("err_range", 32'(ramstate), 32'(ERROR));
        checkOutput("err_range_load", ramload, 32'h0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        readWord(32'h10, 32'hDEADBEEF, "err_unchanged");
        readWord(32'h0, 32'h0, "err_no_alias");

        applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("abort_free", 32'(ramstate), 32'(FREE));
        readWord(32'h20, 32'h0, "abort_rd");

        applyStimulus(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5);
        nRST = 1'b0;
        #1;
        checkOutput("rst_mid", 32'(ramstate), 32'(FREE));
        checkOutput("rst_mid_load", ramload, 32'h0);
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        readWord(32'h10, 32'h0, "rst_cleared");
        readWord(32'h30, 32'h0, "rst_no_commit");

        cur = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) >= 7) begin
                kind = int'($urandom_range(0, 11));
                cur.store = $urandom;
                cur.addr  = 32'($urandom_range(0, 7)) * 4;
                cur.ren   = $urandom_range(0, 1) == 1;
                cur.wen   = !cur.ren;
                case (kind)
                    0: begin cur.ren = 1'b0; cur.wen = 1'b0; end
                    1: begin cur.ren = 1'b1; cur.wen = 1'b1; end
                    2: cur.addr = cur.addr | 32'($urandom_range(1, 3));
                    3: cur.addr = 32'(WORDS * 4) + cur.addr;
                    default: ;
                endcase
            end
            applyStimulus(cur.ren, cur.wen, cur.addr, cur.store);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
